// File: rtl/vc_arbiter_if.sv
// Handshake bundle between the VC0/VC1 FIFOs, the arbiter and the D0/D1 destination FIFOs.
// The master modport is the arbiter side; the slave modport is the FIFO/environment side.
interface vc_arbiter_if #(
  parameter int BW = 6
);
  logic          VC0_empty;
  logic [BW-1:0] VC0_data_out;
  logic          VC1_empty;
  logic [BW-1:0] VC1_data_out;
  logic          D0_almost_full;
  logic          D1_almost_full;
  logic          VC0_rd;
  logic          VC1_rd;
  logic [BW-1:0] data_out;
  logic          D0_push;
  logic          D1_push;
  logic          arb_idle;

  modport master (
    input  VC0_empty, VC0_data_out, VC1_empty, VC1_data_out,
    input  D0_almost_full, D1_almost_full,
    output VC0_rd, VC1_rd, data_out, D0_push, D1_push, arb_idle
  );

  modport slave (
    output VC0_empty, VC0_data_out, VC1_empty, VC1_data_out,
    output D0_almost_full, D1_almost_full,
    input  VC0_rd, VC1_rd, data_out, D0_push, D1_push, arb_idle
  );
endinterface

// File: rtl/vc_arbiter.sv
// Weighted round-robin arbiter popping VC0/VC1 and routing each word to D0/D1 by DEST_BIT.
// Define VC_STRICT_PRIO_EN to replace WRR with strict VC0-over-VC1 priority.
module vc_arbiter #(
  parameter int BW       = 6,
  parameter int DEST_BIT = 4,
  parameter int WEIGHT0  = 4,
  parameter int WEIGHT1  = 1,
  parameter int CW       = 3
) (
  input  logic          clk,
  input  logic          reset_L,
  vc_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          gnt0, gnt1;
  logic          pop_ok;
  logic          vld_q, sel_q;
  logic [BW-1:0] data_q;
  logic          d0_q, d1_q;
  logic [BW-1:0] rd_word;

  // Head destination is unknown before the pop, so both destinations need room.
  assign pop_ok  = ~bus.D0_almost_full & ~bus.D1_almost_full;
  assign rd_word = sel_q ? bus.VC1_data_out : bus.VC0_data_out;

`ifndef VC_STRICT_PRIO_EN
  localparam logic [CW-1:0] W0 = CW'(WEIGHT0);
  localparam logic [CW-1:0] W1 = CW'(WEIGHT1);
`endif

  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    state_nxt = state;
    cnt_nxt   = cnt;
    if (pop_ok) begin
`ifdef VC_STRICT_PRIO_EN
      cnt_nxt = '0;
      if (!bus.VC0_empty) begin
        gnt0      = 1'b1;
        state_nxt = GNT0;
      end else if (!bus.VC1_empty) begin
        gnt1      = 1'b1;
        state_nxt = GNT1;
      end else begin
        state_nxt = IDLE;
      end
`else
      unique case (state)
        IDLE: begin
          if (!bus.VC0_empty) begin
            gnt0      = 1'b1;
            state_nxt = GNT0;
            cnt_nxt   = CW'(1);
          end else if (!bus.VC1_empty) begin
            gnt1      = 1'b1;
            state_nxt = GNT1;
            cnt_nxt   = CW'(1);
          end
        end
        GNT0: begin
          if (!bus.VC0_empty && (cnt < W0 || bus.VC1_empty)) begin
            gnt0    = 1'b1;
            cnt_nxt = (cnt >= W0) ? W0 : cnt + CW'(1);
          end else if (!bus.VC1_empty) begin
            gnt1      = 1'b1;
            state_nxt = GNT1;
            cnt_nxt   = CW'(1);
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
        GNT1: begin
          if (!bus.VC1_empty && (cnt < W1 || bus.VC0_empty)) begin
            gnt1    = 1'b1;
            cnt_nxt = (cnt >= W1) ? W1 : cnt + CW'(1);
          end else if (!bus.VC0_empty) begin
            gnt0      = 1'b1;
            state_nxt = GNT0;
            cnt_nxt   = CW'(1);
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
`endif
    end
  end

  assign bus.VC0_rd = gnt0 & reset_L;
  assign bus.VC1_rd = gnt1 & reset_L;

  // Grant in cycle N -> read data captured at end of N+1 -> push visible in N+2.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state  <= IDLE;
      cnt    <= '0;
      vld_q  <= 1'b0;
      sel_q  <= 1'b0;
      data_q <= '0;
      d0_q   <= 1'b0;
      d1_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      vld_q <= gnt0 | gnt1;
      if (gnt0 | gnt1) sel_q <= gnt1;
      if (vld_q) data_q <= rd_word;
      d0_q  <= vld_q & ~rd_word[DEST_BIT];
      d1_q  <= vld_q &  rd_word[DEST_BIT];
    end
  end

  assign bus.data_out = data_q;
  assign bus.D0_push  = d0_q;
  assign bus.D1_push  = d1_q;
  assign bus.arb_idle = (state == IDLE) & ~vld_q & ~d0_q & ~d1_q;

endmodule

// File: tb/tb_vc_arbiter.sv
// Randomized/directed bench for vc_arbiter against a grant-history reference model.
module tb_vc_arbiter;
  localparam int BW       = 6;
  localparam int DEST_BIT = 4;
  localparam int WEIGHT0  = 4;
  localparam int WEIGHT1  = 1;

  logic clk = 1'b0;
  logic reset_L;
  always #5 clk = ~clk;

  vc_arbiter_if #(.BW(BW)) vif ();

  vc_arbiter #(
    .BW(BW), .DEST_BIT(DEST_BIT), .WEIGHT0(WEIGHT0), .WEIGHT1(WEIGHT1), .CW(3)
  ) dut (
    .clk(clk),
    .reset_L(reset_L),
    .bus(vif.master)
  );

  int vectors = 0;
  int miscompares = 0;

  // FIFO contents as seen by the DUT, and the model's own copy of what is still queued.
  logic [BW-1:0] fq0[$], fq1[$];
  logic [BW-1:0] sb0[$], sb1[$];
  bit            rd0_seen, rd1_seen;
  int            dut_log[$];

  // Reference model: last granted VC (-1 = idle), length of its current run, 2-deep push pipe.
  int            last;
  int            run;
  bit            pv[2];
  logic [BW-1:0] pw[2];
  logic [BW-1:0] exp_dout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int vc, input logic [BW-1:0] w);
    if (vc == 0) begin fq0.push_back(w); sb0.push_back(w); end
    else         begin fq1.push_back(w); sb1.push_back(w); end
  endtask

  task automatic model_reset();
    last = -1; run = 0;
    pv[0] = 1'b0; pv[1] = 1'b0;
    pw[0] = '0;   pw[1] = '0;
    exp_dout = '0;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle();
    int            g;
    bit            e0, e1, pok, exp_idle;
    logic [BW-1:0] w;
    if (rd0_seen && fq0.size() > 0) vif.VC0_data_out = fq0.pop_front();
    if (rd1_seen && fq1.size() > 0) vif.VC1_data_out = fq1.pop_front();
    vif.VC0_empty = (fq0.size() == 0);
    vif.VC1_empty = (fq1.size() == 0);
    #1;
    e0  = sb0.size() > 0;
    e1  = sb1.size() > 0;
    pok = !vif.D0_almost_full && !vif.D1_almost_full;
    g   = -1;
    if (reset_L && pok) begin
`ifdef VC_STRICT_PRIO_EN
      g = e0 ? 0 : (e1 ? 1 : -1);
`else
      if (e0 && e1) begin
        if (last == 0)      g = (run >= WEIGHT0) ? 1 : 0;
        else if (last == 1) g = (run >= WEIGHT1) ? 0 : 1;
        else                g = 0;
      end else begin
        g = e0 ? 0 : (e1 ? 1 : -1);
      end
`endif
    end
    exp_idle = (last == -1) && !pv[0] && !pv[1];
    if (pv[1]) exp_dout = pw[1];

    chk("vc0_rd",   32'(vif.VC0_rd),   32'(g == 0));
    chk("vc1_rd",   32'(vif.VC1_rd),   32'(g == 1));
    chk("d0_push",  32'(vif.D0_push),  32'(pv[1] && !pw[1][DEST_BIT]));
    chk("d1_push",  32'(vif.D1_push),  32'(pv[1] &&  pw[1][DEST_BIT]));
    chk("data_out", 32'(vif.data_out), 32'(exp_dout));
    chk("arb_idle", 32'(vif.arb_idle), 32'(exp_idle));

    w = '0;
    if (g >= 0) begin
      run  = (g == last) ? run + 1 : 1;
      last = g;
      w    = (g == 0) ? sb0.pop_front() : sb1.pop_front();
    end else if (reset_L && pok && !e0 && !e1) begin
      last = -1;
      run  = 0;
    end
    pv[1] = pv[0]; pw[1] = pw[0];
    pv[0] = (g >= 0); pw[0] = w;

    rd0_seen = vif.VC0_rd;
    rd1_seen = vif.VC1_rd;
    if (vif.VC0_rd) dut_log.push_back(0);
    if (vif.VC1_rd) dut_log.push_back(1);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (sb0.size() == 0 && sb1.size() == 0 && last == -1 && !pv[0] && !pv[1]) break;
    end
    #1;
    chk("drained_idle", 32'(vif.arb_idle), 32'd1);
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    reset_L = 1'b0;
    model_reset();
    repeat (cycles) cycle();
    reset_L = 1'b1;
  endtask

  initial begin
    int exp_seq[10];
    reset_L = 1'b1;
    vif.VC0_empty = 1'b1; vif.VC1_empty = 1'b1;
    vif.VC0_data_out = '0; vif.VC1_data_out = '0;
    vif.D0_almost_full = 1'b0; vif.D1_almost_full = 1'b0;
    rd0_seen = 1'b0; rd1_seen = 1'b0;
    model_reset();
    #2;

    // Reset held with both VCs non-empty, then release: VC0 is granted first.
    for (int i = 0; i < 3; i++) begin
      load(0, BW'($urandom));
      load(1, BW'($urandom));
    end
    reset_L = 1'b0;
    @(negedge clk);
    do_reset(3);
    dut_log.delete();
    drain();
    chk("first_after_reset", 32'(dut_log[0]), 32'd0);

    // Single word to D0.
    load(0, 6'h05);
    drain();

    // Weighted round-robin with both VCs loaded.
    for (int i = 0; i < 10; i++) begin
      load(0, BW'($urandom));
      load(1, BW'($urandom));
    end
`ifdef VC_STRICT_PRIO_EN
    exp_seq = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`else
    exp_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif
    dut_log.delete();
    drain();
    for (int i = 0; i < 10; i++) chk($sformatf("grant_seq[%0d]", i), 32'(dut_log[i]), 32'(exp_seq[i]));

    // Destination routing from VC1.
    load(1, 6'h12);
    load(1, 6'h03);
    drain();

    // Backpressure mid-burst.
    for (int i = 0; i < 8; i++) begin
      load(0, BW'($urandom));
      load(1, BW'($urandom));
    end
    repeat (3) cycle();
    vif.D1_almost_full = 1'b1;
    repeat (4) cycle();
    vif.D1_almost_full = 1'b0;
    drain();

    // Random traffic, backpressure and occasional mid-operation reset.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) load(0, BW'($urandom));
      if ($urandom_range(0, 3) == 0) load(1, BW'($urandom));
      vif.D0_almost_full = ($urandom_range(0, 6) == 0);
      vif.D1_almost_full = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 149) == 0) begin
        vif.D0_almost_full = 1'b0;
        vif.D1_almost_full = 1'b0;
        do_reset(2);
      end else begin
        cycle();
      end
    end
    vif.D0_almost_full = 1'b0;
    vif.D1_almost_full = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
